// File: rtl/rover_pwm_pkg.sv
// Shared definitions for the rover PWM generator and capture blocks.
// Holds the capture FSM states and the default sizing constants.
package rover_pwm_pkg;

  localparam int PWM_SIZE    = 12;
  localparam int PWM_PERIOD  = 4000;
  localparam int PWM_TIMEOUT = 4095;

  typedef enum logic [1:0] {
    WAIT_FALL,
    WAIT_RISE,
    HIGH,
    LOW
  } capture_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Brings an asynchronous input into the clock domain with two flops and
// uses a third flop to detect rising and falling edges of the synchronized level.
module pwm_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rising-to-rising period of a PWM input in clocks,
// with a stall timer that flags a stuck input as lost.
module pwm_capture
  import rover_pwm_pkg::*;
#(
  parameter int SIZE    = PWM_SIZE,
  parameter int PERIOD  = PWM_PERIOD,
  parameter int TIMEOUT = PWM_TIMEOUT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            pwm_in,
  output logic [SIZE-1:0] duty,
  output logic [SIZE-1:0] period,
  output logic            valid,
  output logic            lost
);

  localparam logic [SIZE-1:0] CNT_MAX    = '1;
  localparam logic [SIZE-1:0] CNT_ONE    = SIZE'(1);
  localparam logic [SIZE-1:0] STALL_LAST = SIZE'(TIMEOUT - 1);

  if (TIMEOUT < 1 || TIMEOUT > (2 ** SIZE) - 1 || PERIOD < 1) begin : g_param_check
    $error("pwm_capture: TIMEOUT must lie in 1 .. 2**SIZE-1");
  end

  function automatic logic [SIZE-1:0] sat_inc(input logic [SIZE-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic unused_level;
  logic rise, fall, edge_seen, timeout;

  capture_state_e  state, state_nxt;
  logic [SIZE-1:0] period_cnt, period_cnt_nxt;
  logic [SIZE-1:0] high_cnt, high_cnt_nxt;
  logic [SIZE-1:0] stall_cnt, stall_cnt_nxt;
  logic [SIZE-1:0] duty_nxt, period_nxt;
  logic            valid_nxt, lost_nxt;

  pwm_sync_edge u_sync (
    .clock (clock),
    .reset (reset),
    .in    (pwm_in),
    .level (unused_level),
    .rise  (rise),
    .fall  (fall)
  );

  // A detected edge in the same cycle always wins over the stall timeout.
  assign edge_seen = rise | fall;
  assign timeout   = ~edge_seen & (stall_cnt == STALL_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= WAIT_FALL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    period_cnt_nxt = period_cnt;
    high_cnt_nxt   = high_cnt;
    stall_cnt_nxt  = edge_seen ? '0 : sat_inc(stall_cnt);
    duty_nxt       = duty;
    period_nxt     = period;
    valid_nxt      = 1'b0;
    lost_nxt       = lost;

    case (state)
      WAIT_FALL: begin
        if (fall) state_nxt = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise) begin
          state_nxt      = HIGH;
          period_cnt_nxt = CNT_ONE;
          high_cnt_nxt   = CNT_ONE;
        end
      end
      HIGH: begin
        period_cnt_nxt = sat_inc(period_cnt);
        if (fall) state_nxt = LOW;
        else      high_cnt_nxt = sat_inc(high_cnt);
      end
      LOW: begin
        if (rise) begin
          duty_nxt       = high_cnt;
          period_nxt     = period_cnt;
          valid_nxt      = 1'b1;
          lost_nxt       = 1'b0;
          period_cnt_nxt = CNT_ONE;
          high_cnt_nxt   = CNT_ONE;
          state_nxt      = HIGH;
        end else begin
          period_cnt_nxt = sat_inc(period_cnt);
        end
      end
      default: state_nxt = WAIT_FALL;
    endcase

    if (timeout) begin
      state_nxt  = WAIT_FALL;
      duty_nxt   = '0;
      period_nxt = '0;
      valid_nxt  = 1'b0;
      lost_nxt   = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      period_cnt <= '0;
      high_cnt   <= '0;
      stall_cnt  <= '0;
      duty       <= '0;
      period     <= '0;
      valid      <= 1'b0;
      lost       <= 1'b0;
    end else begin
      period_cnt <= period_cnt_nxt;
      high_cnt   <= high_cnt_nxt;
      stall_cnt  <= stall_cnt_nxt;
      duty       <= duty_nxt;
      period     <= period_nxt;
      valid      <= valid_nxt;
      lost       <= lost_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scenario bench for pwm_capture: expected reports are queued as periods are
// driven and matched against each valid pulse by a monitor.
module tb_pwm_capture;

  typedef struct {
    logic [11:0] duty;
    logic [11:0] period;
  } report_t;

  logic        clock, reset, pwm_in;
  logic [11:0] duty, period;
  logic        valid, lost;

  report_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int last_valid_cycle = 0;
  int prev_valid_cycle = 0;
  int valid_cnt = 0;
  logic prev_valid = 1'b0;

  pwm_capture #(.SIZE(12), .PERIOD(4000), .TIMEOUT(4095)) dut (
    .clock  (clock),
    .reset  (reset),
    .pwm_in (pwm_in),
    .duty   (duty),
    .period (period),
    .valid  (valid),
    .lost   (lost)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [11:0] sat12(input int v);
    return (v > 4095) ? 12'd4095 : 12'(v);
  endfunction

  // Every valid pulse must match the oldest queued report and last one cycle.
  always @(negedge clock) begin
    if (!reset) begin
      prev_valid = 1'b0;
    end else begin
      if (valid) begin
        report_t e;
        valid_cnt++;
        prev_valid_cycle = last_valid_cycle;
        last_valid_cycle = cycle;
        checks++;
        if (prev_valid) begin
          errors++;
          $display("[TB] FAIL valid_width: valid high %0d cycles, expected 1", 2);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_valid: duty=%0d period=%0d, expected no valid", duty, period);
        end else begin
          e = exp_q.pop_front();
          if (duty !== e.duty || period !== e.period || lost !== 1'b0) begin
            errors++;
            $display("[TB] FAIL report: duty=%0d period=%0d lost=%0b, expected duty=%0d period=%0d lost=0",
                     duty, period, lost, e.duty, e.period);
          end
        end
      end
      prev_valid = valid;
    end
    cycle++;
  end

  task automatic apply_reset(input logic level);
    pwm_in = level;
    reset  = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic drive_period(input int h, input int l, input bit push);
    if (push) exp_q.push_back('{duty: sat12(h), period: sat12(h + l)});
    pwm_in = 1'b1;
    repeat (h) @(negedge clock);
    pwm_in = 1'b0;
    repeat (l) @(negedge clock);
  endtask

  task automatic close_stream();
    pwm_in = 1'b1;
    repeat (6) @(negedge clock);
  endtask

  task automatic test_reset();
    pwm_in = 1'b0;
    reset  = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({duty, period, valid, lost} !== 26'b0) begin
      errors++;
      $display("[TB] FAIL reset_hold: duty=%0d period=%0d valid=%0b lost=%0b, expected all 0", duty, period, valid, lost);
    end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({duty, period, valid, lost} !== 26'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: duty=%0d period=%0d valid=%0b lost=%0b, expected all 0", duty, period, valid, lost);
    end
  endtask

  task automatic test_steady();
    apply_reset(1'b0);
    drive_period(20, 20, 0);
    for (int i = 0; i < 3; i++) drive_period(1000, 3001, 1);
    pwm_in = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_early: valid=%0b two clocks after rise, expected 0", valid);
    end
    @(negedge clock);
    checks++;
    if (valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency: valid=%0b three clocks after rise, expected 1", valid);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (last_valid_cycle - prev_valid_cycle !== 4001) begin
      errors++;
      $display("[TB] FAIL valid_spacing: %0d clocks, expected 4001", last_valid_cycle - prev_valid_cycle);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL steady_drain: %0d reports pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_high_at_reset();
    int base;
    apply_reset(1'b1);
    base = valid_cnt;
    repeat (500) @(negedge clock);
    pwm_in = 1'b0;
    repeat (3001) @(negedge clock);
    drive_period(1000, 3001, 1);
    close_stream();
    checks++;
    if (valid_cnt - base !== 1 || exp_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL high_at_reset: %0d valids with %0d pending, expected 1 valid and 0 pending",
               valid_cnt - base, exp_q.size());
    end
  endtask

  task automatic test_lost();
    apply_reset(1'b0);
    drive_period(20, 20, 0);
    drive_period(1000, 3001, 1);
    pwm_in = 1'b1;
    repeat (1000) @(negedge clock);
    pwm_in = 1'b0;
    repeat (4097) @(negedge clock);
    checks++;
    if (lost !== 1'b0 || duty !== 12'd1000) begin
      errors++;
      $display("[TB] FAIL lost_early: lost=%0b duty=%0d at 4094 clocks, expected lost=0 duty=1000", lost, duty);
    end
    @(negedge clock);
    checks++;
    if (lost !== 1'b1 || duty !== 12'd0 || period !== 12'd0) begin
      errors++;
      $display("[TB] FAIL lost_assert: lost=%0b duty=%0d period=%0d, expected 1/0/0", lost, duty, period);
    end
    drive_period(20, 20, 0);
    drive_period(1000, 3001, 1);
    pwm_in = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (lost !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lost_hold: lost=%0b before resume valid, expected 1", lost);
    end
    @(negedge clock);
    checks++;
    if (lost !== 1'b0 || valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lost_clear: lost=%0b valid=%0b, expected lost=0 valid=1", lost, valid);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL lost_drain: %0d reports pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_duty_change();
    apply_reset(1'b0);
    drive_period(20, 20, 0);
    drive_period(1000, 3001, 1);
    drive_period(2500, 1501, 1);
    drive_period(2500, 1501, 1);
    close_stream();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL duty_change_drain: %0d reports pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    apply_reset(1'b0);
    drive_period(20, 20, 0);
    drive_period(1000, 3001, 1);
    pwm_in = 1'b1;
    repeat (1000) @(negedge clock);
    pwm_in = 1'b0;
    repeat (1500) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({duty, period, valid, lost} !== 26'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: duty=%0d period=%0d valid=%0b lost=%0b, expected all 0", duty, period, valid, lost);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    drive_period(20, 20, 0);
    drive_period(1000, 3001, 1);
    close_stream();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_drain: %0d reports pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_saturation();
    apply_reset(1'b0);
    drive_period(20, 20, 0);
    drive_period(4000, 4000, 1);
    close_stream();
    checks++;
    if (exp_q.size() !== 0 || lost !== 1'b0) begin
      errors++;
      $display("[TB] FAIL saturation: %0d pending lost=%0b, expected 0 pending lost=0", exp_q.size(), lost);
    end
  endtask

  initial begin
    reset  = 1'b0;
    pwm_in = 1'b0;
    test_reset();
    test_steady();
    test_high_at_reset();
    test_lost();
    test_duty_change();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform and reports its high time and period in clock cycles. It is the receive-side counterpart of the rover's PWM generator: it decodes RC-receiver or motor-feedback PWM into numeric `duty`/`period` values for the control logic. One measurement is produced per input period, with a loss-of-signal flag for stuck inputs.

## Interface
- `SIZE`, 12: width of the `duty`, `period` and internal counters.
- `PERIOD`, 4000: nominal input period in clocks; informational only, exported to the package default.
- `TIMEOUT`, 4095: clocks without any detected edge before `lost` asserts; must satisfy 1 ≤ TIMEOUT ≤ 2^SIZE−1.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pwm_in`  in  1  asynchronous PWM input.
- `duty`  out  SIZE  high-phase length of the last complete period, in clocks.
- `period`  out  SIZE  rising-to-rising length of the last complete period, in clocks.
- `valid`  out  1  one-cycle pulse when `duty`/`period` update.
- `lost`  out  1  signal-lost flag, level.

## Operation
- `pwm_in` passes through a 2-flop synchronizer, then a third flop for edge detection.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - The synchronizer flops reset to 0.
- States:
  - WAIT_FALL (reset state): a fall goes to WAIT_RISE. This rejects the false rise caused when the input is high at reset release.
  - WAIT_RISE: a rise goes to HIGH; `period_cnt` and `high_cnt` are set to 1.
  - HIGH: both counters increment each cycle; a fall goes to LOW.
  - LOW: `period_cnt` increments each cycle. A rise sets `duty` ← `high_cnt`, `period` ← `period_cnt`, `valid` ← 1 and `lost` ← 0, restarts both counters at 1, and goes to HIGH.
- Counters saturate at 2^SIZE−1 and never wrap; the reported value is then all-ones.
- Stall timer:
  - Counts clocks since the last detected edge in any state; cleared on every rise or fall; saturates.
  - When it reaches TIMEOUT: `lost` ← 1, `duty` ← 0, `period` ← 0, state ← WAIT_FALL, no `valid`.
  - This covers both 0% and 100% duty inputs.
- Simultaneous events: a rise and the timeout in the same cycle resolve in favour of the edge, so no loss is reported.
- No `valid` is generated in WAIT_FALL or WAIT_RISE. The first `valid` follows the second rise after the first fall.

## Timing
- Reset values: `duty` = 0, `period` = 0, `valid` = 0, `lost` = 0, state WAIT_FALL, all counters 0.
- Reset is asynchronous: asserting it mid-measurement clears everything immediately and discards the measurement in progress.
- Latency: `valid` rises on the 3rd rising `clock` edge after `pwm_in` rises (2 synchronizer stages plus the output register).
- Both edges have equal latency, so the reported widths are exact, ±1 clock of input sampling jitter.
- `valid` is high for exactly one cycle. `duty` and `period` are held stable until the next `valid` or timeout.
- Input pulses shorter than 2 clocks may be missed; this is not detected.
- `lost` asserts on the cycle the stall timer equals TIMEOUT and stays high until the next `valid`.

## Structure
- Package `rover_pwm_pkg` holds:
  - the state enum (WAIT_FALL, WAIT_RISE, HIGH, LOW);
  - the default constants SIZE = 12, PERIOD = 4000 and TIMEOUT = 4095, shared with the PWM generator.
- Sub-module `pwm_sync_edge` holds the 3-flop synchronizer and edge detector. Ports: `clock`, `reset`, `in`, `level`, `rise`, `fall`.
- The top level holds the FSM, the counters, the stall timer and the output registers.

## Test plan
1. Steady input, 1000 high / 3001 low: after startup, `valid` pulses every 4001 clocks with `duty` = 1000, `period` = 4001, `lost` = 0.
2. `pwm_in` high at reset release: no `valid` until after the first fall followed by two rises. The first report is 1000/4001, not truncated.
3. Input stuck low after a valid measurement: `lost` = 1 exactly 4095 clocks after the last edge, `duty` = `period` = 0, no `valid`. When the waveform resumes, `lost` clears with the first new `valid`.
4. Duty changed from 1000 to 2500 mid-stream: the next `valid` reports 1000 or 2500 according to the period in which the change landed, never an intermediate value. Subsequent reports are 2500/4001.
5. `reset` pulsed low during the LOW phase: all outputs read 0 in the same cycle. Measurement restarts from WAIT_FALL, and the first `valid` is correct.
6. Input 4000 high / 4000 low (sum exceeds the counter range): `period` = 4095 (saturated), `duty` = 4000, `lost` = 0.
